// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the MMU requesters, the arbiter and the downstream memory port.
// The slave modport is the arbiter's view; the master modport is the MMU/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic                  flush;

  logic                  inst_rden;
  logic [ADDR_WIDTH-1:0] inst_riaddr;
  logic                  inst_rvalid;
  logic [ADDR_WIDTH-1:0] inst_roaddr;
  logic [DATA_WIDTH-1:0] inst_rdata;

  logic                  data_rden;
  logic [ADDR_WIDTH-1:0] data_riaddr;
  logic                  data_rvalid;
  logic [ADDR_WIDTH-1:0] data_roaddr;
  logic [DATA_WIDTH-1:0] data_rdata;

  logic                  data_wren;
  logic [ADDR_WIDTH-1:0] data_waddr;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic [SW-1:0]         data_wstrb;

  logic                  inst_wait;
  logic                  data_wait;
  logic                  mem_wait;

  logic                  m_req;
  logic                  m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [SW-1:0]         m_wstrb;
  logic                  m_ack;
  logic                  m_rvalid;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_bvalid;

  modport slave (
    input  flush,
    input  inst_rden, inst_riaddr,
    output inst_rvalid, inst_roaddr, inst_rdata,
    input  data_rden, data_riaddr,
    output data_rvalid, data_roaddr, data_rdata,
    input  data_wren, data_waddr, data_wdata, data_wstrb,
    output inst_wait, data_wait, mem_wait,
    output m_req, m_we, m_addr, m_wdata, m_wstrb,
    input  m_ack, m_rvalid, m_rdata, m_bvalid
  );

  modport master (
    output flush,
    output inst_rden, inst_riaddr,
    input  inst_rvalid, inst_roaddr, inst_rdata,
    output data_rden, data_riaddr,
    input  data_rvalid, data_roaddr, data_rdata,
    output data_wren, data_waddr, data_wdata, data_wstrb,
    input  inst_wait, data_wait, mem_wait,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb,
    output m_ack, m_rvalid, m_rdata, m_bvalid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between inst read, data read and data write
// requesters: one-entry slots, fixed priority with inst anti-starvation, single outstanding.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_port_arbiter_if.slave io_bus,
  output logic [1:0]        o_dbg_state
);
  // Handshakes: upstream *_RDEN/*_WREN are one-cycle pulses accepted only while the
  // matching WAIT is low; M_REQ holds with stable M_* fields until M_ACK is sampled high,
  // then exactly one M_RVALID (read) or M_BVALID (write) closes the transaction.
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  localparam logic [1:0] G_INST = 2'd0;
  localparam logic [1:0] G_RD   = 2'd1;
  localparam logic [1:0] G_WR   = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RWAIT, S_WWAIT} state_t;

  state_t r_state, w_next;

  logic                  r_inst_full, r_inst_cancel;
  logic [ADDR_WIDTH-1:0] r_inst_addr;
  logic                  r_rd_full;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_wr_full;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [SW-1:0]         r_wr_strb;

  logic [1:0]            r_gnt;
  logic [CW-1:0]         r_starve;

  logic                  r_inst_rvalid, r_data_rvalid;
  logic [ADDR_WIDTH-1:0] r_inst_roaddr, r_data_roaddr;
  logic [DATA_WIDTH-1:0] r_inst_rdata, r_data_rdata;

  logic       w_grant;
  logic [1:0] w_gnt_sel;
  logic       w_inst_elig;
  logic       w_inst_busy;
  logic       w_rsp, w_rsp_inst, w_rsp_rd, w_wr_done;

  assign w_inst_elig = r_inst_full && !io_bus.flush;
  assign w_inst_busy = (r_state != S_IDLE) && (r_gnt == G_INST);
  assign w_rsp       = (r_state == S_RWAIT) && io_bus.m_rvalid;
  assign w_rsp_inst  = w_rsp && (r_gnt == G_INST);
  assign w_rsp_rd    = w_rsp && (r_gnt == G_RD);
  assign w_wr_done   = (r_state == S_WWAIT) && io_bus.m_bvalid;

  // Write beats data read so a same-address read observes the write.
  always_comb begin
    w_grant   = 1'b0;
    w_gnt_sel = G_INST;
    if (r_state == S_IDLE) begin
      if (w_inst_elig && (r_starve == STARVE_MAX)) begin
        w_grant = 1'b1;
        w_gnt_sel = G_INST;
      end else if (r_wr_full) begin
        w_grant = 1'b1;
        w_gnt_sel = G_WR;
      end else if (r_rd_full) begin
        w_grant = 1'b1;
        w_gnt_sel = G_RD;
      end else if (w_inst_elig) begin
        w_grant = 1'b1;
        w_gnt_sel = G_INST;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_next = S_REQ;
      S_REQ:   if (io_bus.m_ack) w_next = (r_gnt == G_WR) ? S_WWAIT : S_RWAIT;
      S_RWAIT: if (io_bus.m_rvalid) w_next = S_IDLE;
      S_WWAIT: if (io_bus.m_bvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields come straight from the granted slot, which cannot change while granted.
  always_comb begin
    io_bus.m_req   = 1'b0;
    io_bus.m_we    = 1'b0;
    io_bus.m_addr  = '0;
    io_bus.m_wdata = '0;
    io_bus.m_wstrb = '0;
    if (r_state == S_REQ) begin
      io_bus.m_req = 1'b1;
      case (r_gnt)
        G_WR: begin
          io_bus.m_we    = 1'b1;
          io_bus.m_addr  = r_wr_addr;
          io_bus.m_wdata = r_wr_data;
          io_bus.m_wstrb = r_wr_strb;
        end
        G_RD:    io_bus.m_addr = r_rd_addr;
        default: io_bus.m_addr = r_inst_addr;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt         <= G_INST;
      r_starve      <= '0;
      r_inst_full   <= 1'b0;
      r_inst_cancel <= 1'b0;
      r_inst_addr   <= '0;
      r_rd_full     <= 1'b0;
      r_rd_addr     <= '0;
      r_wr_full     <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_strb     <= '0;
      r_inst_rvalid <= 1'b0;
      r_inst_roaddr <= '0;
      r_inst_rdata  <= '0;
      r_data_rvalid <= 1'b0;
      r_data_roaddr <= '0;
      r_data_rdata  <= '0;
    end else begin
      r_inst_rvalid <= 1'b0;
      r_data_rvalid <= 1'b0;

      if (w_grant) begin
        r_gnt <= w_gnt_sel;
        if (w_gnt_sel == G_INST)
          r_starve <= '0;
        else if (r_inst_full && (r_starve != STARVE_MAX))
          r_starve <= r_starve + CW'(1);
      end else if (!r_inst_full) begin
        r_starve <= '0;
      end

      // A flush on an in-flight inst read lets it finish downstream but drops the reply.
      if (!r_inst_full) begin
        if (io_bus.inst_rden) begin
          r_inst_full   <= 1'b1;
          r_inst_cancel <= 1'b0;
          r_inst_addr   <= io_bus.inst_riaddr;
        end
      end else if (w_rsp_inst) begin
        r_inst_full   <= 1'b0;
        r_inst_cancel <= 1'b0;
        if (!(r_inst_cancel || io_bus.flush)) begin
          r_inst_rvalid <= 1'b1;
          r_inst_roaddr <= r_inst_addr;
          r_inst_rdata  <= io_bus.m_rdata;
        end
      end else if (io_bus.flush) begin
        if (w_inst_busy) r_inst_cancel <= 1'b1;
        else             r_inst_full   <= 1'b0;
      end

      if (!r_rd_full) begin
        if (io_bus.data_rden) begin
          r_rd_full <= 1'b1;
          r_rd_addr <= io_bus.data_riaddr;
        end
      end else if (w_rsp_rd) begin
        r_rd_full     <= 1'b0;
        r_data_rvalid <= 1'b1;
        r_data_roaddr <= r_rd_addr;
        r_data_rdata  <= io_bus.m_rdata;
      end

      if (!r_wr_full) begin
        if (io_bus.data_wren) begin
          r_wr_full <= 1'b1;
          r_wr_addr <= io_bus.data_waddr;
          r_wr_data <= io_bus.data_wdata;
          r_wr_strb <= io_bus.data_wstrb;
        end
      end else if (w_wr_done) begin
        r_wr_full <= 1'b0;
      end
    end
  end

  assign io_bus.inst_rvalid = r_inst_rvalid;
  assign io_bus.inst_roaddr = r_inst_roaddr;
  assign io_bus.inst_rdata  = r_inst_rdata;
  assign io_bus.data_rvalid = r_data_rvalid;
  assign io_bus.data_roaddr = r_data_roaddr;
  assign io_bus.data_rdata  = r_data_rdata;
  assign io_bus.inst_wait   = r_inst_full;
  assign io_bus.data_wait   = r_rd_full | r_wr_full;
  assign io_bus.mem_wait    = r_inst_full | r_rd_full | r_wr_full;
  assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written sequences for ordering, starvation, flush, ack stall and reset.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .io_bus      (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    string         name;
    logic [1:0]    kind;      // 0 inst read, 1 data read, 2 data write
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] rdata;
    logic          exp_we;
    logic [SW-1:0] exp_mstrb;
    logic          exp_iwait;
    logic          exp_dwait;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.flush = 0;
    bus.inst_rden = 0; bus.inst_riaddr = '0;
    bus.data_rden = 0; bus.data_riaddr = '0;
    bus.data_wren = 0; bus.data_waddr = '0; bus.data_wdata = '0; bus.data_wstrb = '0;
    bus.m_ack = 0; bus.m_rvalid = 0; bus.m_rdata = '0; bus.m_bvalid = 0;
  endtask

  task automatic pulse(input bit do_inst, input bit do_rd, input bit do_wr,
                       input logic [AW-1:0] iaddr, input logic [AW-1:0] raddr,
                       input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] wstrb);
    bus.inst_rden = do_inst; bus.inst_riaddr = iaddr;
    bus.data_rden = do_rd;   bus.data_riaddr = raddr;
    bus.data_wren = do_wr;   bus.data_waddr = waddr;
    bus.data_wdata = wdata;  bus.data_wstrb = wstrb;
    tick();
    bus.inst_rden = 0; bus.data_rden = 0; bus.data_wren = 0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!bus.m_req && n < 50) begin
      tick();
      n++;
    end
    check({name, "_req"}, bus.m_req, 1);
  endtask

  task automatic do_ack();
    bus.m_ack = 1;
    tick();
    bus.m_ack = 0;
  endtask

  task automatic read_resp(input logic [DW-1:0] d);
    tick();
    bus.m_rvalid = 1; bus.m_rdata = d;
    tick();
    bus.m_rvalid = 0; bus.m_rdata = '0;
  endtask

  task automatic write_resp();
    bus.m_bvalid = 1;
    tick();
    bus.m_bvalid = 0;
  endtask

  task automatic drain();
    bit we;
    for (int k = 0; k < 10 && (bus.mem_wait || bus.m_req); k++) begin
      wait_req("drain");
      we = bus.m_we;
      do_ack();
      if (we) write_resp();
      else read_resp('0);
      tick();
    end
    check("drain_empty", bus.mem_wait, 0);
  endtask

  initial begin
    vec_t v;
    int data_grants;
    bit inst_seen;
    bit was_wr;

    vecs[0] = '{"inst_boot", 2'd0, 32'h2000_0000, 32'h0, 4'h0, 32'h0000_0013, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[1] = '{"data_rd",   2'd1, 32'h0000_0100, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 4'h0, 1'b0, 1'b1};
    vecs[2] = '{"wr_half",   2'd2, 32'h0000_0104, 32'h1234_5678, 4'h3, 32'h0, 1'b1, 4'h3, 1'b0, 1'b1};
    vecs[3] = '{"wr_top",    2'd2, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 4'hF, 1'b0, 1'b1};
    vecs[4] = '{"inst_top",  2'd0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[5] = '{"rd_zero",   2'd1, 32'h0000_0000, 32'h0, 4'h0, 32'h8000_0001, 1'b0, 4'h0, 1'b0, 1'b1};

    // clock/reset
    idle_inputs();
    rst = 1;
    repeat (3) tick();
    rst = 0;
    tick();
    check("rst_m_req", bus.m_req, 0);
    check("rst_m_we", bus.m_we, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_m_wdata", bus.m_wdata, 0);
    check("rst_m_wstrb", bus.m_wstrb, 0);
    check("rst_inst_wait", bus.inst_wait, 0);
    check("rst_data_wait", bus.data_wait, 0);
    check("rst_mem_wait", bus.mem_wait, 0);
    check("rst_inst_rvalid", bus.inst_rvalid, 0);
    check("rst_data_rvalid", bus.data_rvalid, 0);
    check("rst_inst_rdata", bus.inst_rdata, 0);
    check("rst_state", dbg_state, 0);

    // single transactions from the table
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      pulse(v.kind == 0, v.kind == 1, v.kind == 2, v.addr, v.addr, v.addr, v.wdata, v.wstrb);
      check({v.name, "_inst_wait"}, bus.inst_wait, v.exp_iwait);
      check({v.name, "_data_wait"}, bus.data_wait, v.exp_dwait);
      check({v.name, "_mem_wait"}, bus.mem_wait, v.exp_iwait | v.exp_dwait);
      check({v.name, "_req_latency"}, bus.m_req, 0);
      tick();
      check({v.name, "_m_req"}, bus.m_req, 1);
      check({v.name, "_m_we"}, bus.m_we, v.exp_we);
      check({v.name, "_m_addr"}, bus.m_addr, v.addr);
      check({v.name, "_m_wstrb"}, bus.m_wstrb, v.exp_mstrb);
      if (v.exp_we) check({v.name, "_m_wdata"}, bus.m_wdata, v.wdata);
      do_ack();
      check({v.name, "_req_drop"}, bus.m_req, 0);
      if (v.kind != 2) begin
        exp_q.push_back(v.rdata);
        read_resp(v.rdata);
        if (v.kind == 0) begin
          check({v.name, "_inst_rvalid"}, bus.inst_rvalid, 1);
          check({v.name, "_data_rvalid"}, bus.data_rvalid, 0);
          check({v.name, "_roaddr"}, bus.inst_roaddr, v.addr);
          check({v.name, "_rdata"}, bus.inst_rdata, exp_q.pop_front());
        end else begin
          check({v.name, "_data_rvalid"}, bus.data_rvalid, 1);
          check({v.name, "_inst_rvalid"}, bus.inst_rvalid, 0);
          check({v.name, "_roaddr"}, bus.data_roaddr, v.addr);
          check({v.name, "_rdata"}, bus.data_rdata, exp_q.pop_front());
        end
        check({v.name, "_wait_clear"}, bus.mem_wait, 0);
        tick();
        check({v.name, "_rvalid_pulse"}, bus.inst_rvalid | bus.data_rvalid, 0);
      end else begin
        write_resp();
        check({v.name, "_wait_clear"}, bus.data_wait, 0);
        check({v.name, "_no_rvalid"}, bus.inst_rvalid | bus.data_rvalid, 0);
        tick();
      end
    end

    // same-cycle write and read to one address: write goes first
    pulse(0, 1, 1, '0, 32'h100, 32'h100, 32'hDEAD_BEEF, 4'hF);
    wait_req("raw_wr");
    check("raw_first_we", bus.m_we, 1);
    check("raw_first_addr", bus.m_addr, 32'h100);
    check("raw_first_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    check("raw_first_wstrb", bus.m_wstrb, 4'hF);
    do_ack();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("raw_rd_held", bus.m_req, 0);
    end
    write_resp();
    check("raw_rd_pending", bus.data_wait, 1);
    tick();
    check("raw_rd_req", bus.m_req, 1);
    check("raw_rd_we", bus.m_we, 0);
    check("raw_rd_addr", bus.m_addr, 32'h100);
    do_ack();
    exp_q.push_back(32'hDEAD_BEEF);
    read_resp(32'hDEAD_BEEF);
    check("raw_rd_rvalid", bus.data_rvalid, 1);
    check("raw_rd_rdata", bus.data_rdata, exp_q.pop_front());
    tick();

    // inst starvation: data slots refilled after every completion
    pulse(1, 1, 1, 32'h4000, 32'h200, 32'h300, 32'h11, 4'hF);
    data_grants = 0;
    inst_seen = 0;
    for (int g = 0; g < 8 && !inst_seen; g++) begin
      wait_req("starve");
      if (!bus.m_we && bus.m_addr == 32'h4000) begin
        inst_seen = 1;
        do_ack();
        read_resp(32'h77);
        check("starve_inst_rvalid", bus.inst_rvalid, 1);
        check("starve_inst_rdata", bus.inst_rdata, 32'h77);
        tick();
      end else begin
        data_grants++;
        was_wr = bus.m_we;
        do_ack();
        if (was_wr) write_resp();
        else read_resp(32'h55);
        pulse(0, !was_wr, was_wr, '0, 32'h200, 32'h300, 32'h11, 4'hF);
      end
    end
    check("starve_inst_seen", inst_seen, 1);
    check("starve_data_grants", data_grants, 4);
    drain();

    // flush of an in-flight inst read
    pulse(1, 0, 0, 32'h3000, '0, '0, '0, '0);
    wait_req("flush_busy");
    do_ack();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    check("flush_busy_wait_held", bus.inst_wait, 1);
    read_resp(32'h99);
    check("flush_busy_no_rvalid", bus.inst_rvalid, 0);
    check("flush_busy_wait_drop", bus.inst_wait, 0);
    tick();
    check("flush_busy_no_rvalid2", bus.inst_rvalid, 0);
    bus.flush = 1;
    pulse(1, 0, 0, 32'h3004, '0, '0, '0, '0);
    bus.flush = 0;
    check("flush_same_cycle_capture", bus.inst_wait, 1);
    wait_req("flush_new");
    check("flush_new_addr", bus.m_addr, 32'h3004);
    do_ack();
    read_resp(32'hAB);
    check("flush_new_rvalid", bus.inst_rvalid, 1);
    check("flush_new_roaddr", bus.inst_roaddr, 32'h3004);
    check("flush_new_rdata", bus.inst_rdata, 32'hAB);
    tick();

    // flush of a pending (not granted) inst slot
    pulse(1, 0, 1, 32'h5000, '0, 32'h600, 32'h1, 4'h1);
    wait_req("flush_idle");
    check("flush_idle_wr_first", bus.m_we, 1);
    bus.flush = 1;
    tick();
    bus.flush = 0;
    check("flush_idle_slot_cleared", bus.inst_wait, 0);
    do_ack();
    write_resp();
    repeat (3) tick();
    check("flush_idle_no_req", bus.m_req, 0);
    check("flush_idle_all_empty", bus.mem_wait, 0);

    // ack stall: request fields hold for 20 cycles
    pulse(0, 0, 1, '0, '0, 32'hA5A5_0000, 32'h5A5A_1234, 4'h9);
    wait_req("stall");
    for (int k = 0; k < 20; k++) begin
      check("stall_m_req", bus.m_req, 1);
      check("stall_m_addr", bus.m_addr, 32'hA5A5_0000);
      check("stall_m_wdata", bus.m_wdata, 32'h5A5A_1234);
      check("stall_m_wstrb", bus.m_wstrb, 4'h9);
      tick();
    end
    do_ack();
    write_resp();
    tick();

    // reset in the middle of a write
    pulse(0, 1, 1, '0, 32'h700, 32'h704, 32'hF0F0, 4'hF);
    wait_req("rst_mid");
    do_ack();
    check("rst_mid_in_wwait", dbg_state, 2'd3);
    rst = 1;
    #1;
    check("rst_mid_async_state", dbg_state, 0);
    check("rst_mid_async_wait", bus.mem_wait, 0);
    tick();
    rst = 0;
    tick();
    bus.m_bvalid = 1;
    tick();
    bus.m_bvalid = 0;
    check("rst_late_b_state", dbg_state, 0);
    check("rst_late_b_req", bus.m_req, 0);
    check("rst_late_b_wait", bus.mem_wait, 0);
    check("rst_late_b_rvalid", bus.inst_rvalid | bus.data_rvalid, 0);
    repeat (3) tick();
    check("rst_late_b_idle", bus.m_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
